seq_shl_unit: RTL and testbench
===============================

SEQ_SHL_UNIT -- requirements
Module: seq_shl_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width. Result width is 2*WIDTH. Shift-amount width is log2(WIDTH), i.e. 5.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled at the rising edge.
REQ-005 a  input  32  operand, treated as unsigned and zero-extended to 64 bits.
REQ-006 b  input  32  shift amount; only b[4:0] is used, b[31:5] is ignored.
REQ-007 busy  output  1  high while a shift is in progress.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 result  output  64  registered left-shift result {hi[31:0], lo[31:0]}.
REQ-010 hi_nz  output  1  registered flag; high when result[63:32] != 0.

Function
REQ-011 The block SHALL compute result = ({32'h0, a} << b[4:0]) with zero fill from the LSB, iteratively, one bit position per clock. It is the left-shift counterpart of the team's combinational 64-bit arithmetic-right shifter.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; the encoding is implementation choice.
REQ-013 Acceptance: start=1 in IDLE or DONE at edge E0 SHALL
- latch a zero-extended into a 64-bit working register,
- latch b[4:0] into a 5-bit down-counter cnt,
- move the FSM to SHIFT.
REQ-014 In SHIFT with cnt != 0, each edge SHALL shift the working register left by 1 (bit 0 <- 0) and decrement cnt.
REQ-015 In SHIFT with cnt == 0, the next edge SHALL copy the working register to result, update hi_nz, and move to DONE.
REQ-016 For shift amount k, done SHALL be high for exactly the one cycle following edge E0+k+1. Total latency is k+2 cycles; for k=0 done follows edge E0+1.
REQ-017 busy SHALL be high exactly while the state is SHIFT, i.e. from edge E0 through edge E0+k+1.
REQ-018 In DONE without start, the next edge SHALL return the FSM to IDLE. done SHALL never be high for two consecutive cycles unless a new operation of k=0 completes back-to-back.
REQ-019 start while busy=1 SHALL be ignored, with no effect on cnt, the working register, or the eventual result.
REQ-020 result and hi_nz SHALL hold their last values from the DONE transition until the next completion. They SHALL NOT change during SHIFT.
REQ-021 a and b SHALL be sampled only at the acceptance edge; input changes afterwards SHALL have no effect.
REQ-022 Bits shifted past bit 63 cannot occur (max shift 31 of a 32-bit value), so no bits SHALL be lost and there is no overflow output.

Reset
REQ-023 While reset=1 at an edge, the block SHALL set: FSM=IDLE, busy=0, done=0, result=64'h0, hi_nz=0, cnt=0, working register=0.
REQ-024 Reset SHALL take priority over start at the same edge; that start SHALL be discarded.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse and with result cleared to 0.

Verification
REQ-026 a=32'h80000001, b=1, start one cycle -> busy high 2 cycles, done after edge E0+2, result=64'h00000001_00000002, hi_nz=1.
REQ-027 a=32'hFFFFFFFF, b=31 -> done after edge E0+32, result=64'h7FFFFFFF_80000000, hi_nz=1, busy high 32 cycles.
REQ-028 a=32'h1234ABCD, b=32'hFFFFFFE0 (b[4:0]=0) -> done after edge E0+1, result=64'h00000000_1234ABCD, hi_nz=0.
REQ-029 a=32'h1, b=4, then start pulsed again at E0+2 with a=32'hFFFF, b=0 -> second start ignored, result=64'h0000000000000010, single done pulse.
REQ-030 a=32'hF, b=8, reset asserted at E0+3 -> no done pulse, result=0, busy=0. Next start with a=32'h3, b=2 -> result=64'h0000000C.
REQ-031 start asserted during the DONE cycle with a=32'h2, b=3 -> accepted, busy high next cycle, result=64'h10 after edge E0+4.

Source files
------------

// File: rtl/seq_shl_unit.sv
// seq_shl_unit: iterative left shifter, one bit position per clock, zero-extended operand into a 2*WIDTH result
module seq_shl_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               hi_nz_o
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] work_q, work_d, result_q, result_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               hi_nz_q, hi_nz_d;
  logic               unused_b;
  assign unused_b = ^b_i[WIDTH-1:SW];
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    hi_nz_d  = hi_nz_q;
    if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        work_d = {work_q[2*WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - SW'(1);
      end else begin
        result_d = work_q;
        hi_nz_d  = |work_q[2*WIDTH-1:WIDTH];
        state_d  = DONE;
      end
    end else if (start_i) begin
      work_d  = {{WIDTH{1'b0}}, a_i};
      cnt_d   = b_i[SW-1:0];
      state_d = SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      hi_nz_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      hi_nz_q  <= hi_nz_d;
    end
  end
  assign busy_o   = state_q == SHIFT;
  assign done_o   = state_q == DONE;
  assign result_o = result_q;
  assign hi_nz_o  = hi_nz_q;
endmodule

// File: tb/tb_seq_shl_unit.sv
// tb_seq_shl_unit: cycle-level reference model plus directed vectors with literal expectations
module tb_seq_shl_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, hi_nz;
  logic [63:0] result;
  int          n_cmp = 0, n_bad = 0;
  seq_shl_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result), .hi_nz_o(hi_nz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: an accepted op keeps the unit busy for k+1 cycles, then the result appears with a done pulse
  int          m_left = 0;
  logic [63:0] m_pending = '0, m_result = '0;
  logic        m_done = 1'b0;
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_left   = 0;
      m_result = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_result = m_pending;
        m_done   = 1'b1;
      end
    end else if (start) begin
      m_pending = {32'h0, a} << b[4:0];
      m_left    = int'(b[4:0]) + 1;
    end
  end
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("result", result, m_result);
    chk("hi_nz", 64'(hi_nz), 64'(m_result[63:32] != 0));
  end
  task automatic launch(input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask
  task automatic wait_done(output int j);
    j = 0;
    while (!done && j < 100) begin
      @(negedge clk);
      j++;
    end
  endtask
  task automatic op(input string name, input logic [31:0] va, input logic [31:0] vb,
                    input logic [63:0] exp, input logic exp_hi, input int exp_lat);
    int j;
    launch(va, vb);
    wait_done(j);
    chk({name, "_lat"}, 64'(j), 64'(exp_lat));
    chk({name, "_res"}, result, exp);
    chk({name, "_hinz"}, 64'(hi_nz), 64'(exp_hi));
  endtask
  initial begin
    int j, dcnt;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    op("r026", 32'h80000001, 32'd1, 64'h00000001_00000002, 1'b1, 2);
    @(negedge clk);
    op("r027", 32'hFFFFFFFF, 32'd31, 64'h7FFFFFFF_80000000, 1'b1, 32);
    op("r028", 32'h1234ABCD, 32'hFFFFFFE0, 64'h00000000_1234ABCD, 1'b0, 1);
    @(negedge clk);
    op("misc", 32'hDEADBEEF, 32'd16, 64'h0000DEAD_BEEF0000, 1'b1, 17);
    repeat (2) @(negedge clk);
    launch(32'h1, 32'd4);
    @(negedge clk);
    launch(32'hFFFF, 32'd0);
    dcnt = 0;
    repeat (20) begin
      if (done) begin
        dcnt++;
        chk("r029_res", result, 64'h10);
      end
      @(negedge clk);
    end
    chk("r029_pulses", 64'(dcnt), 64'd1);
    launch(32'hF, 32'd8);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r030_busy", 64'(busy), 64'h0);
    chk("r030_res", result, 64'h0);
    dcnt = 0;
    repeat (15) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("r030_nodone", 64'(dcnt), 64'd0);
    op("r030b", 32'h3, 32'd2, 64'h0000000C, 1'b0, 3);
    launch(32'h2, 32'd3);
    chk("r031_busy", 64'(busy), 64'h1);
    wait_done(j);
    chk("r031_lat", 64'(j), 64'd4);
    chk("r031_res", result, 64'h10);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
